frame_scan_reader: RTL and testbench
====================================

// Module: frame_scan_reader
// PURPOSE
//  Read-side master for the dual-port frame buffer. On each frame_start it requests a snapshot
//  (raises r_rd and tracks r_done through the copy). It then raster-scans the snapshot by driving
//  r_addr and streams pixels out on a valid/ready interface toward the display/processing path.
//  One clock domain (the buffer read clock).
// PARAMETERS
//  IMG_W    256  pixels per line (power of 2)
//  IMG_H    256  lines per frame
//  ADDR_W   16   r_addr width; IMG_W*IMG_H <= 2**ADDR_W
//  DATA_W   16   pixel width (RGB565)
//  TIMEOUT  8    max cycles in REQ waiting for r_done to fall
// PORTS
//  r_clk        in   1       clock (buffer read clock)
//  rst          in   1       synchronous reset, active-high
//  frame_start  in   1       1-cycle request for a new frame; ignored unless IDLE
//  r_rd         out  1       snapshot request level to buffer
//  r_done       in   1       buffer copy-complete flag (1 = idle/complete)
//  r_addr       out  ADDR_W  buffer read address
//  r_data       in   DATA_W  buffer read data; registered, valid 1 cycle after r_addr
//  px_data      out  DATA_W  output pixel
//  px_valid     out  1       px_data valid
//  px_ready     in   1       downstream accept; transfer = px_valid & px_ready
//  px_sof       out  1       qualifies pixel (0,0)
//  px_eol       out  1       qualifies last pixel of each line
//  px_eof       out  1       qualifies last pixel of frame
//  busy         out  1       1 in any state except IDLE
//  err_timeout  out  1       sticky; set on REQ timeout; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; output buffer emptied. Reset mid-frame drops r_rd
//   and any buffered pixels in the same cycle.
//  FSM:
//   IDLE  frame_start -> REQ
//   REQ   r_rd=1. r_done==0 -> COPY (also covers a copy left stalled by an earlier reset).
//         TIMEOUT cycles elapse with r_done==1 -> set err_timeout, go to GAP.
//   COPY  r_rd=1. r_done==1 -> SCAN; r_rd falls on SCAN entry.
//   SCAN  r_rd=0. Issue addresses 0..IMG_W*IMG_H-1 in raster order (addr = y*IMG_W + x).
//         After the last pixel is transferred -> GAP.
//   GAP   r_rd=0 for 2 cycles (the buffer needs a fresh rising edge) -> IDLE.
//  Scan pipeline:
//   - 2-entry output FIFO. An address is issued in a cycle only if (entries + in-flight) < 2.
//   - Data captured from r_data the cycle after issue; sof/eol/eof tags travel with the address.
//   - With px_ready held 1: one pixel per cycle; first px_valid 2 cycles after SCAN entry.
//   - Backpressure: px_data and the flags hold stable while px_valid & !px_ready. No pixel is
//     lost or duplicated.
//  Boundaries:
//   - x wraps IMG_W-1 -> 0 and increments y. eol is on x == IMG_W-1.
//   - eof on the final address; sof and eof are never both set unless IMG_W*IMG_H == 1.
//   - frame_start outside IDLE is ignored (no queueing).
//   - Simultaneous frame_start and rst: rst wins.
//   - r_done rising in REQ before it has fallen is not treated as completion.
// CONFIGURATION
//  FSR_GRAY_EN defined:
//   - Each pixel loaded into the output FIFO is converted to gray; no added latency.
//   - Expand to 8 bits: R8={r,r[4:2]}, G8={g,g[5:4]}, B8={b,b[4:2]}.
//   - Y = (77*R8 + 150*G8 + 29*B8) >> 8 (16-bit intermediate).
//   - px_data = {Y[7:3], Y[7:2], Y[7:3]}.
//  FSR_GRAY_EN undefined: px_data = r_data unchanged.
// TESTING
//  1. Model buffer: r_done falls 3 cycles after r_rd rises, rises 65538 cycles later; pulse frame_start
//     -> r_rd high until r_done rises, then 65536 transfers, sof@addr0, eol every 256th, eof@65535.
//  2. r_data = address model, px_ready=1 -> px_data sequence 0,1,...,65535; no gaps after first valid.
//  3. px_ready random 50% -> same ordered sequence, no drops/dups; px_data stable while stalled.
//  4. r_done held 1 -> after 8 cycles in REQ, err_timeout=1, r_rd=0, busy falls 2 cycles later.
//  5. rst at pixel 1000 -> r_rd=0, px_valid=0 next cycle; model left with r_done=0; new frame_start
//     -> REQ goes straight to COPY; frame completes.
//  6. FSR_GRAY_EN, r_data=16'hFFFF -> 16'hFFFF; 16'hF800 -> Y=76 -> px_data=16'h4A69.

Source files
------------

// File: rtl/frame_scan_reader.sv
// Frame buffer read master: snapshot handshake, raster scan, valid/ready pixel stream.
// Define FSR_GRAY_EN to convert RGB565 pixels to gray-level RGB565 on load.
module frame_scan_reader #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              r_clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              r_rd,
  input  logic              r_done,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              px_sof,
  output logic              px_eol,
  output logic              px_eof,
  output logic              busy,
  output logic              err_timeout
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_COPY, S_SCAN, S_GAP
  } state_t;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic              eof;
    logic [DATA_W-1:0] d;
  } ent_t;

  state_t            st_q, st_d;
  logic [TW-1:0]     tc_q, tc_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic              idone_q, idone_d;
  logic              infl_q, infl_d;
  logic [2:0]        tag_q, tag_d;
  logic [1:0]        cnt_q, cnt_d;
  ent_t              e0_q, e0_d;
  ent_t              e1_q, e1_d;

  logic       pop, issue, last_a, eol_a;
  logic [1:0] occ;
  ent_t       new_e;

  function automatic logic [DATA_W-1:0] to_px(input logic [DATA_W-1:0] d);
`ifdef FSR_GRAY_EN
    logic [7:0]  r8, g8, b8;
    logic [15:0] y;
    r8 = {d[15:11], d[15:13]};
    g8 = {d[10:5], d[10:9]};
    b8 = {d[4:0], d[4:2]};
    y  = (16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8}
        + 16'd29 * {8'd0, b8}) >> 8;
    return DATA_W'({y[7:3], y[7:2], y[7:3]});
`else
    return d;
`endif
  endfunction

  assign pop    = (cnt_q != 2'd0) && px_ready;
  // Count the slot freed by this cycle's pop so full rate is sustained.
  assign occ    = cnt_q - {1'b0, pop} + {1'b0, infl_q};
  assign issue  = (st_q == S_SCAN) && !idone_q && (occ < 2'd2);
  assign last_a = addr_q == ADDR_W'(NPIX - 1);
  assign eol_a  = x_q == XW'(IMG_W - 1);

  assign new_e.sof = tag_q[2];
  assign new_e.eol = tag_q[1];
  assign new_e.eof = tag_q[0];
  assign new_e.d   = to_px(r_data);

  always_comb begin
    st_d  = st_q;
    tc_d  = tc_q;
    err_d = err_q;
    unique case (st_q)
      S_IDLE: if (frame_start) begin
        st_d = S_REQ;
        tc_d = '0;
      end
      S_REQ: if (!r_done) begin
        st_d = S_COPY;
      end else if (tc_q == TW'(TIMEOUT - 1)) begin
        st_d  = S_GAP;
        err_d = 1'b1;
        tc_d  = '0;
      end else begin
        tc_d = tc_q + 1'b1;
      end
      S_COPY: if (r_done) st_d = S_SCAN;
      S_SCAN: if (pop && e0_q.eof) begin
        st_d = S_GAP;
        tc_d = '0;
      end
      S_GAP: if (tc_q == TW'(1)) st_d = S_IDLE;
             else tc_d = tc_q + 1'b1;
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    x_d     = x_q;
    idone_d = idone_q;
    infl_d  = issue;
    tag_d   = {addr_q == '0, eol_a, last_a};
    if (st_q != S_SCAN) begin
      addr_d  = '0;
      x_d     = '0;
      idone_d = 1'b0;
    end else if (issue) begin
      if (last_a) begin
        idone_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
        x_d    = eol_a ? '0 : x_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
    if (infl_q) begin
      if (cnt_d == 2'd0) e0_d = new_e;
      else               e1_d = new_e;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      tc_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      x_q     <= '0;
      idone_q <= 1'b0;
      infl_q  <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      st_q    <= st_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      idone_q <= idone_d;
      infl_q  <= infl_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign r_rd        = (st_q == S_REQ) || (st_q == S_COPY);
  assign busy        = st_q != S_IDLE;
  assign err_timeout = err_q;
  assign r_addr      = addr_q;
  assign px_valid    = cnt_q != 2'd0;
  assign px_data     = e0_q.d;
  assign px_sof      = px_valid && e0_q.sof;
  assign px_eol      = px_valid && e0_q.eol;
  assign px_eof      = px_valid && e0_q.eof;

endmodule

// File: tb/tb_frame_scan_reader.sv
// Random-stimulus bench for frame_scan_reader on a small frame with a
// behavioural buffer model and a per-frame expected pixel list.
module tb_frame_scan_reader;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int COPY = 20;

  logic        r_clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        r_rd;
  logic        r_done = 1'b1;
  logic [15:0] r_addr;
  logic [15:0] r_data = '0;
  logic [15:0] px_data;
  logic        px_valid;
  logic        px_ready = 1'b1;
  logic        px_sof, px_eol, px_eof;
  logic        busy, err_timeout;

  logic [15:0] mem [NPIX];
  logic        hold_done = 1'b0;
  logic        rd_prev = 1'b0;
  int          fcnt = 0;
  int          rcnt = 0;
  int          total = 0;
  int          bad = 0;

  frame_scan_reader #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(16), .DATA_W(16), .TIMEOUT(8)
  ) dut (
    .r_clk(r_clk), .rst(rst), .frame_start(frame_start),
    .r_rd(r_rd), .r_done(r_done), .r_addr(r_addr),
    .r_data(r_data), .px_data(px_data), .px_valid(px_valid),
    .px_ready(px_ready), .px_sof(px_sof), .px_eol(px_eol),
    .px_eof(px_eof), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 r_clk = ~r_clk;

  // Buffer model: registered read, copy starts on a fresh r_rd rise.
  always @(posedge r_clk) begin
    r_data  <= mem[int'(r_addr) % NPIX];
    rd_prev <= r_rd;
    if (hold_done) begin
      r_done <= 1'b1;
      fcnt   <= 0;
      rcnt   <= 0;
    end else if (r_rd && !rd_prev && r_done && fcnt == 0 && rcnt == 0) begin
      fcnt <= 3;
    end else if (fcnt > 0) begin
      fcnt <= fcnt - 1;
      if (fcnt == 1) begin
        r_done <= 1'b0;
        rcnt   <= COPY;
      end
    end else if (rcnt > 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1) r_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] px_model(input logic [15:0] d);
`ifdef FSR_GRAY_EN
    int r8, g8, b8, y;
    logic [7:0] yb;
    r8 = int'(d[15:11]) * 8 + int'(d[15:13]);
    g8 = int'(d[10:5]) * 4 + int'(d[10:9]);
    b8 = int'(d[4:0]) * 8 + int'(d[4:2]);
    y  = (77 * r8 + 150 * g8 + 29 * b8) / 256;
    yb = 8'(y);
    return {yb[7:3], yb[7:2], yb[7:3]};
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] exp_px(input int k);
    logic s, l, e;
    s = (k == 0);
    l = (k % W) == W - 1;
    e = (k == NPIX - 1);
    return {13'd0, s, l, e, px_model(mem[k])};
  endfunction

  task automatic pulse_fs();
    @(negedge r_clk) frame_start = 1'b1;
    @(negedge r_clk) frame_start = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input int abort_at,
                           input bit poke_fs);
    int idx, nx, first_v;
    bit fell, stalled, done_f;
    logic [31:0] prev_o, cur_o;
    for (int k = 0; k < NPIX; k++) mem[k] = 16'($urandom);
    mem[0] = 16'hF800;
    mem[1] = 16'hFFFF;
    idx = -1; nx = 0; first_v = -1;
    fell = 0; stalled = 0; done_f = 0; prev_o = '0;
    pulse_fs();
    for (int b = 0; b < 2000 && !done_f; b++) begin
      if (b > 0) @(negedge r_clk);
      if (!fell) begin
        if (r_rd) continue;
        fell = 1;
        idx = 0;
        check("rd_fall_done", {31'd0, r_done}, 1);
      end else begin
        idx++;
      end
      if (idx == abort_at) begin
        rst = 1'b1;
        @(negedge r_clk);
        rst = 1'b0;
        check("rst_rd", {31'd0, r_rd}, 0);
        check("rst_valid", {31'd0, px_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        return;
      end
      cur_o = {13'd0, px_sof, px_eol, px_eof, px_data};
      if (stalled) check("stall_hold", {px_valid, cur_o[30:0]},
                         {1'b1, prev_o[30:0]});
      if (px_valid && first_v < 0) first_v = idx;
      frame_start = poke_fs && idx == 5;
      px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (px_valid && px_ready) begin
        check("pixel", cur_o, exp_px(nx < NPIX ? nx : NPIX - 1));
        nx++;
        if (px_eof) done_f = 1;
      end
      stalled = px_valid && !px_ready;
      prev_o  = cur_o;
    end
    frame_start = 1'b0;
    px_ready = 1'b1;
    check("frame_count", nx, NPIX);
    if (!rnd) begin
      check("first_valid", first_v, 2);
      check("eof_idx", idx, NPIX + 1);
    end
    @(negedge r_clk) check("gap0_busy", {31'd0, busy}, 1);
    check("gap0_valid", {31'd0, px_valid}, 0);
    @(negedge r_clk) check("gap1_busy", {31'd0, busy}, 1);
    @(negedge r_clk) check("idle_busy", {31'd0, busy}, 0);
    check("idle_rd", {31'd0, r_rd}, 0);
    if (poke_fs) begin
      repeat (4) @(negedge r_clk);
      check("no_queue_busy", {31'd0, busy}, 0);
    end
  endtask

  initial begin
    int n;
    bit vseen;
    for (int k = 0; k < NPIX; k++) mem[k] = '0;
    repeat (3) @(negedge r_clk);
    check("rst_outs", {24'd0, r_rd, px_valid, busy, err_timeout,
                       px_sof, px_eol, px_eof, 1'b0}, 0);
    check("rst_addr", {16'd0, r_addr}, 0);
    rst = 1'b0;

    run_frame(0, -1, 1);
    repeat (3) run_frame(1, -1, 0);

    run_frame(1, 10, 0);
    run_frame(1, -1, 0);

    pulse_fs();
    n = 0;
    while (r_done && n < 50) begin
      @(negedge r_clk);
      n++;
    end
    check("copy_started", {31'd0, r_done}, 0);
    repeat (3) @(negedge r_clk);
    check("copy_rd", {31'd0, r_rd}, 1);
    rst = 1'b1;
    @(negedge r_clk) rst = 1'b0;
    check("copy_rst_rd", {31'd0, r_rd}, 0);
    check("copy_rst_busy", {31'd0, busy}, 0);
    run_frame(0, -1, 0);
    check("no_err", {31'd0, err_timeout}, 0);

    @(negedge r_clk);
    rst = 1'b1;
    frame_start = 1'b1;
    @(negedge r_clk);
    rst = 1'b0;
    frame_start = 1'b0;
    check("rst_wins", {31'd0, busy}, 0);
    @(negedge r_clk) check("rst_wins2", {30'd0, busy, r_rd}, 0);

    hold_done = 1'b1;
    pulse_fs();
    n = 0;
    vseen = 0;
    for (int i = 0; i < 40 && r_rd; i++) begin
      n++;
      if (px_valid) vseen = 1;
      @(negedge r_clk);
    end
    check("tmo_cycles", n, 8);
    check("tmo_err", {31'd0, err_timeout}, 1);
    check("tmo_busy0", {31'd0, busy}, 1);
    check("tmo_novalid", {31'd0, vseen}, 0);
    @(negedge r_clk) check("tmo_busy1", {31'd0, busy}, 1);
    @(negedge r_clk) check("tmo_idle", {31'd0, busy}, 0);
    hold_done = 1'b0;
    @(negedge r_clk);

    run_frame(1, -1, 0);
    check("err_sticky", {31'd0, err_timeout}, 1);
    rst = 1'b1;
    @(negedge r_clk) rst = 1'b0;
    check("err_clear", {31'd0, err_timeout}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
